// File: rtl/lsu_axil_pkg.sv
// Shared types and encodings for the LSU AXI-lite master: FSM states, access sizes,
// AXI response codes and byte-strobe / alignment helpers.
package lsu_axil_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_RD_A    = 3'd1;
  localparam state_t S_RD_D    = 3'd2;
  localparam state_t S_WR_AW_W = 3'd3;
  localparam state_t S_WR_B    = 3'd4;
  localparam state_t S_RESP    = 3'd5;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Lanes shifted past byte 3 fall off the 4-bit result on purpose.
  function automatic logic [3:0] size_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    unique case (size)
      SZ_B:    strb = 4'b0001 << off;
      SZ_H:    strb = 4'b0011 << off;
      SZ_W:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_axil_master_if.sv
// AXI-lite read/write channel bundle between the LSU master and the data-memory responder.
interface lsu_axil_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wen;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wen, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wen, wvalid, output wready,
    output bresp, bvalid, input bready
  );

endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a 32-bit read beat and zero/sign-extends it.
module lsu_load_align
  import lsu_axil_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {off, 3'b000};
    unique case (size)
      SZ_B:    data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SZ_H:    data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_axil_master.sv
// Blocking single-outstanding AXI-lite master for LSU loads/stores.
// Optional misalignment trap when LSU_MISALIGN_CHECK_EN is defined.
module lsu_axil_master
  import lsu_axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  lsu_axil_master_if.master bus
);

  if (DATA_W != 32) begin : gen_bad_data_w
    $error("lsu_axil_master: only DATA_W == 32 is supported");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              bad_req;
  logic [DATA_W-1:0] load_data;

  lsu_load_align u_align (
    .word      (bus.rdata),
    .off       (addr_q[1:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .data      (load_data)
  );

  always_comb begin
    bad_req = (req_size == SZ_RSV);
`ifdef LSU_MISALIGN_CHECK_EN
    bad_req = bad_req || is_misaligned(req_size, req_addr[1:0]);
`endif
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    size_d    = size_q;
    signed_d  = signed_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          size_d    = req_size;
          signed_d  = req_signed;
          rdata_d   = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (bad_req) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_wen) begin
            state_d = S_WR_AW_W;
          end else begin
            state_d = S_RD_A;
          end
        end
      end
      S_RD_A: if (bus.arready) state_d = S_RD_D;
      S_RD_D: begin
        if (bus.rvalid) begin
          rdata_d = load_data;
          err_d   = (bus.rresp != RESP_OKAY);
          state_d = S_RESP;
        end
      end
      S_WR_AW_W: begin
        // AW and W finish independently, in either order or together.
        aw_done_d = aw_done_q | (bus.awvalid & bus.awready);
        w_done_d  = w_done_q | (bus.wvalid & bus.wready);
        if (aw_done_d && w_done_d) state_d = S_WR_B;
      end
      S_WR_B: begin
        if (bus.bvalid) begin
          err_d   = (bus.bresp != RESP_OKAY);
          state_d = S_RESP;
        end
      end
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Valids decode straight from state so an async reset drops them at once.
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    rsp_valid   = (state_q == S_RESP);
    rsp_rdata   = rdata_q;
    rsp_err     = err_q;
    bus.araddr  = addr_q;
    bus.arvalid = (state_q == S_RD_A);
    bus.rready  = (state_q == S_RD_D);
    bus.awaddr  = addr_q;
    bus.awvalid = (state_q == S_WR_AW_W) && !aw_done_q;
    bus.wvalid  = (state_q == S_WR_AW_W) && !w_done_q;
    bus.wen     = bus.wvalid;
    bus.wdata   = wdata_q;
    bus.wstrb   = bus.wvalid ? size_strb(size_q, addr_q[1:0]) : 4'b0000;
    bus.bready  = (state_q == S_WR_B);
  end

endmodule

// File: tb/tb_lsu_axil_master.sv
// Directed bench for lsu_axil_master: responder is driven cycle-by-cycle from the tasks.
module tb_lsu_axil_master;
  import lsu_axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  lsu_axil_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_axil_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus        (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic sg);
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd;
    req_size = sz; req_signed = sg;
    tick();
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b00; req_signed = 1'b0;
  endtask

  // Stimulus only: runs a zero-wait load and returns what the response port showed.
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                          input logic [31:0] rd, input logic [1:0] rr,
                          output logic [31:0] got_d, output logic got_e, output logic got_v);
    bus.arready = 1'b1;
    send_req(1'b0, a, 32'h0, sz, sg);
    tick();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = rd; bus.rresp = rr;
    tick();
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = RESP_OKAY;
    @(negedge clk);
    got_v = rsp_valid; got_d = rsp_rdata; got_e = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.wen,
         bus.bready} !== 8'b1000_0000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b want 10000000", {req_ready, rsp_valid, bus.arvalid,
               bus.rready, bus.awvalid, bus.wvalid, bus.wen, bus.bready});
    end
    n_checks++;
    if ({rsp_rdata, rsp_err, bus.wstrb, bus.araddr} !== 69'h0) begin
      n_errors++;
      $display("FAIL reset_data: rdata=%h err=%b wstrb=%b araddr=%h want all 0",
               rsp_rdata, rsp_err, bus.wstrb, bus.araddr);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_load_byte();
    bus.arready = 1'b0;
    send_req(1'b0, 32'h8000_0003, 32'h0, SZ_B, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({bus.arvalid, bus.rready, bus.araddr} !== {2'b10, 32'h8000_0003}) begin
      n_errors++;
      $display("FAIL ldb_ar: arvalid=%b rready=%b araddr=%h want 1 0 80000003",
               bus.arvalid, bus.rready, bus.araddr);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h8000_0003}) begin
      n_errors++;
      $display("FAIL ldb_ar_hold: arvalid=%b araddr=%h want 1 80000003", bus.arvalid, bus.araddr);
    end
    tick();
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.arvalid, bus.rready} !== 2'b01) begin
      n_errors++;
      $display("FAIL ldb_rready: arvalid=%b rready=%b want 0 1", bus.arvalid, bus.rready);
    end
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'h8A00_0000; bus.rresp = RESP_OKAY;
    tick();
    bus.rvalid = 1'b0; bus.rdata = '0;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hFFFF_FF8A}) begin
      n_errors++;
      $display("FAIL ldb_rsp: valid=%b err=%b rdata=%h want 1 0 ffffff8a",
               rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL ldb_idle: req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_load_half();
    logic [31:0] d;
    logic        e, v;
    tick();
    run_load(32'h0000_0102, SZ_H, 1'b0, 32'hF00D_1234, RESP_OKAY, d, e, v);
    n_checks++;
    if ({v, e, d} !== {2'b10, 32'h0000_F00D}) begin
      n_errors++;
      $display("FAIL ldh_unsigned: valid=%b err=%b rdata=%h want 1 0 0000f00d", v, e, d);
    end
    run_load(32'h0000_0102, SZ_H, 1'b1, 32'hF00D_1234, RESP_OKAY, d, e, v);
    n_checks++;
    if ({v, e, d} !== {2'b10, 32'hFFFF_F00D}) begin
      n_errors++;
      $display("FAIL ldh_signed: valid=%b err=%b rdata=%h want 1 0 fffff00d", v, e, d);
    end
  endtask

  task automatic test_store_half();
    int b_acc = 0;
    bus.awready = 1'b0; bus.wready = 1'b1;
    send_req(1'b1, 32'h8000_0002, 32'h0000_BEEF, SZ_H, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.wen, bus.wstrb, bus.wdata, bus.awaddr} !==
        {3'b111, 4'b1100, 32'h0000_BEEF, 32'h8000_0002}) begin
      n_errors++;
      $display("FAIL sth_w: awv=%b wv=%b wen=%b wstrb=%b wdata=%h awaddr=%h", bus.awvalid,
               bus.wvalid, bus.wen, bus.wstrb, bus.wdata, bus.awaddr);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b100) begin
        n_errors++;
        $display("FAIL sth_aw_wait%0d: awv=%b wv=%b bready=%b want 1 0 0", c, bus.awvalid,
                 bus.wvalid, bus.bready);
      end
    end
    tick();
    bus.awready = 1'b1;
    tick();
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b1; bus.bresp = RESP_OKAY;
    @(negedge clk);
    if (bus.bvalid && bus.bready) b_acc++;
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, rsp_valid} !== 4'b0010) begin
      n_errors++;
      $display("FAIL sth_b: awv=%b wv=%b bready=%b rsp_valid=%b want 0 0 1 0", bus.awvalid,
               bus.wvalid, bus.bready, rsp_valid);
    end
    tick();
    @(negedge clk);
    if (bus.bvalid && bus.bready) b_acc++;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin
      n_errors++;
      $display("FAIL sth_rsp: valid=%b err=%b rdata=%h want 1 0 0", rsp_valid, rsp_err,
               rsp_rdata);
    end
    n_checks++;
    if (b_acc !== 1) begin
      n_errors++;
      $display("FAIL sth_b_count: got %0d want 1", b_acc);
    end
    tick();
    bus.bvalid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_store_same_cycle();
    bus.awready = 1'b1; bus.wready = 1'b1;
    send_req(1'b1, 32'h0000_0040, 32'h1122_3344, SZ_W, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.wstrb} !== {2'b11, 4'b1111}) begin
      n_errors++;
      $display("FAIL stw_both: awv=%b wv=%b wstrb=%b want 1 1 1111", bus.awvalid, bus.wvalid,
               bus.wstrb);
    end
    tick();
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b1; bus.bresp = RESP_SLVERR;
    @(negedge clk);
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) begin
      n_errors++;
      $display("FAIL stw_wrb: awv=%b wv=%b bready=%b want 0 0 1", bus.awvalid, bus.wvalid,
               bus.bready);
    end
    tick();
    bus.bvalid = 1'b0; bus.bresp = RESP_OKAY;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
      n_errors++;
      $display("FAIL stw_slverr: valid=%b err=%b rdata=%h want 1 1 0", rsp_valid, rsp_err,
               rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    // Byte store in the top lane.
    send_req(1'b1, 32'h0000_0043, 32'h0000_00A5, SZ_B, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({bus.wstrb, bus.wdata} !== {4'b1000, 32'h0000_00A5}) begin
      n_errors++;
      $display("FAIL stb_strb: wstrb=%b wdata=%h want 1000 000000a5", bus.wstrb, bus.wdata);
    end
    bus.awready = 1'b1; bus.wready = 1'b1;
    tick();
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_read_error();
    logic [31:0] d;
    logic        e, v;
    run_load(32'h0000_0000, SZ_W, 1'b0, 32'h0, RESP_SLVERR, d, e, v);
    n_checks++;
    if ({v, e, d} !== {2'b11, 32'h0}) begin
      n_errors++;
      $display("FAIL rderr_rsp: valid=%b err=%b rdata=%h want 1 1 0", v, e, d);
    end
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL rderr_idle: req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reserved_size();
    tick();
    send_req(1'b0, 32'h0000_0100, 32'h0, SZ_RSV, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_err, bus.arvalid, bus.awvalid, rsp_rdata} !== {4'b1100, 32'h0}) begin
      n_errors++;
      $display("FAIL rsv_size: valid=%b err=%b arv=%b awv=%b rdata=%h want 1 1 0 0 0",
               rsp_valid, rsp_err, bus.arvalid, bus.awvalid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.arready = 1'b1;
    send_req(1'b0, 32'h0000_0010, 32'h0, SZ_W, 1'b0);
    tick();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h1234_5678;
    tick();
    bus.rvalid = 1'b0; bus.rdata = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {3'b100, 32'h1234_5678}) begin
        n_errors++;
        $display("FAIL bp_hold%0d: valid=%b req_ready=%b err=%b rdata=%h want 1 0 0 12345678",
                 c, rsp_valid, req_ready, rsp_err, rsp_rdata);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.arready = 1'b1;
    send_req(1'b0, 32'h0000_0020, 32'h0, SZ_W, 1'b0);
    tick();
    bus.arready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_rd_d: rready=%b want 1", bus.rready);
    end
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.arvalid, bus.rready, rsp_valid} !== 3'b000) begin
      n_errors++;
      $display("FAIL rst_mid_drop: arv=%b rready=%b rsp_valid=%b want 0 0 0", bus.arvalid,
               bus.rready, rsp_valid);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({req_ready, rsp_valid, bus.arvalid} !== 3'b100) begin
        n_errors++;
        $display("FAIL rst_mid_after%0d: req_ready=%b rsp_valid=%b arv=%b want 1 0 0", c,
                 req_ready, rsp_valid, bus.arvalid);
      end
      tick();
    end
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_CHECK_EN
    int ar_seen = 0;
    send_req(1'b0, 32'h8000_0001, 32'h0, SZ_W, 1'b0);
    @(negedge clk);
    if (bus.arvalid) ar_seen++;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
      n_errors++;
      $display("FAIL mis_trap: valid=%b err=%b rdata=%h want 1 1 0", rsp_valid, rsp_err,
               rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    if (bus.arvalid) ar_seen++;
    n_checks++;
    if (ar_seen !== 0) begin
      n_errors++;
      $display("FAIL mis_no_ar: arvalid seen %0d cycles want 0", ar_seen);
    end
`else
    bus.arready = 1'b0;
    send_req(1'b0, 32'h8000_0001, 32'h0, SZ_W, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h8000_0001}) begin
      n_errors++;
      $display("FAIL mis_ar: arvalid=%b araddr=%h want 1 80000001", bus.arvalid, bus.araddr);
    end
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hAABB_CCDD;
    tick();
    bus.rvalid = 1'b0; bus.rdata = '0;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h00AA_BBCC}) begin
      n_errors++;
      $display("FAIL mis_rsp: valid=%b err=%b rdata=%h want 1 0 00aabbcc", rsp_valid, rsp_err,
               rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b00; req_signed = 1'b0; rsp_ready = 1'b0;
    bus.arready = 1'b0; bus.rdata = '0; bus.rresp = RESP_OKAY; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bresp = RESP_OKAY; bus.bvalid = 1'b0;
    test_reset();
    test_load_byte();
    test_load_half();
    test_store_half();
    test_store_same_cycle();
    test_read_error();
    test_reserved_size();
    test_backpressure();
    test_reset_mid();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
